// File: rtl/iob_eth_rx_word_reader.sv
// RX-data word reader: packs bytes from the RX ring buffer into CSR words
// and acknowledges the MAC once a frame has been consumed or flushed.
module iob_eth_rx_word_reader #(
    parameter int DATA_W     = 32,
    parameter int BUF_ADDR_W = 11,
    parameter int LEN_W      = 12
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  rst_i,
    input  logic                  req_ren_i,
    output logic                  req_ready_o,
    output logic [DATA_W-1:0]     req_rdata_o,
    output logic                  req_rvalid_o,
    input  logic                  frame_rdy_i,
    input  logic [LEN_W-1:0]      frame_len_i,
    output logic                  frame_ack_o,
    input  logic                  flush_i,
    output logic [LEN_W-1:0]      rx_remaining_o,
    output logic                  buf_ren_o,
    output logic [BUF_ADDR_W-1:0] buf_addr_o,
    input  logic [7:0]            buf_rdata_i
);

    localparam int NB = DATA_W / 8;
    localparam int CNT_W = $clog2(NB + 1);
    localparam int unsigned BUF_BYTES = 2 ** BUF_ADDR_W;

    typedef enum logic [2:0] {
        WAIT_FRAME,
        IDLE_RDY,
        FETCH,
        RESP,
        ZRESP
    } state_t;

    state_t                state;
    logic [BUF_ADDR_W-1:0] ptr;
    logic [LEN_W-1:0]      remaining;
    logic [CNT_W-1:0]      k;
    logic [CNT_W-1:0]      n_iss;
    logic [CNT_W-1:0]      n_cap;
    logic                  cap_vld;
    logic [DATA_W-1:0]     acc;
    logic [DATA_W-1:0]     acc_nxt;
    logic [CNT_W-1:0]      k_new;
    logic [LEN_W-1:0]      len_clip;
    logic                  req_acc;

    assign rx_remaining_o = remaining;

    always_comb begin
        req_acc = req_ren_i & req_ready_o;
        k_new = (remaining >= LEN_W'(NB)) ? CNT_W'(NB) : CNT_W'(remaining);
        len_clip = (32'(frame_len_i) > BUF_BYTES) ? LEN_W'(BUF_BYTES) : frame_len_i;
        acc_nxt = acc;
        acc_nxt[8*int'(n_cap) +: 8] = buf_rdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= WAIT_FRAME;
            ptr          <= '0;
            remaining    <= '0;
            k            <= '0;
            n_iss        <= '0;
            n_cap        <= '0;
            cap_vld      <= 1'b0;
            acc          <= '0;
            req_rdata_o  <= '0;
            req_rvalid_o <= 1'b0;
            req_ready_o  <= 1'b1;
            frame_ack_o  <= 1'b0;
            buf_ren_o    <= 1'b0;
            buf_addr_o   <= '0;
        end else if (cke_i) begin
            req_rvalid_o <= 1'b0;
            frame_ack_o  <= 1'b0;
            cap_vld      <= buf_ren_o;
            unique case (state)
                WAIT_FRAME: begin
                    if (req_acc) begin
                        state        <= ZRESP;
                        req_ready_o  <= 1'b0;
                        req_rvalid_o <= 1'b1;
                        req_rdata_o  <= '0;
                    end else if (frame_rdy_i) begin
                        remaining <= len_clip;
                        if (len_clip == '0) frame_ack_o <= 1'b1;
                        else state <= IDLE_RDY;
                    end
                end
                IDLE_RDY: begin
                    if (req_acc) begin
                        state       <= FETCH;
                        req_ready_o <= 1'b0;
                        k           <= k_new;
                        buf_ren_o   <= 1'b1;
                        buf_addr_o  <= ptr;
                        n_iss       <= CNT_W'(1);
                        n_cap       <= '0;
                        acc         <= '0;
                    end else if (flush_i) begin
                        ptr         <= ptr + BUF_ADDR_W'(remaining);
                        remaining   <= '0;
                        frame_ack_o <= 1'b1;
                        state       <= WAIT_FRAME;
                    end
                end
                FETCH: begin
                    if (n_iss < k) begin
                        buf_addr_o <= buf_addr_o + 1'b1;
                        n_iss      <= n_iss + 1'b1;
                    end else begin
                        buf_ren_o <= 1'b0;
                    end
                    // bytes arrive one cycle behind their address
                    if (cap_vld) begin
                        acc   <= acc_nxt;
                        n_cap <= n_cap + 1'b1;
                        if (n_cap == k - CNT_W'(1)) begin
                            req_rdata_o  <= acc_nxt;
                            req_rvalid_o <= 1'b1;
                            ptr          <= ptr + BUF_ADDR_W'(k);
                            remaining    <= remaining - LEN_W'(k);
                            if (remaining == LEN_W'(k)) frame_ack_o <= 1'b1;
                            state        <= RESP;
                        end
                    end
                end
                RESP: begin
                    state       <= (remaining == '0) ? WAIT_FRAME : IDLE_RDY;
                    req_ready_o <= 1'b1;
                end
                ZRESP: begin
                    state       <= WAIT_FRAME;
                    req_ready_o <= 1'b1;
                end
                default: begin
                    state       <= WAIT_FRAME;
                    req_ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iob_eth_rx_word_reader.sv
// Bench for iob_eth_rx_word_reader: directed cases plus random traffic
// compared against a transaction-level ring/frame model.
module tb_iob_eth_rx_word_reader;

    logic        clk = 1'b0;
    logic        cke;
    logic        rst;
    logic        req_ren;
    logic        req_ready;
    logic [31:0] req_rdata;
    logic        req_rvalid;
    logic        frame_rdy;
    logic [11:0] frame_len;
    logic        frame_ack;
    logic        flush;
    logic [11:0] rx_remaining;
    logic        buf_ren;
    logic [10:0] buf_addr;
    logic [7:0]  buf_rdata;

    logic [7:0] mem [2048];

    int n_chk = 0;
    int n_err = 0;
    int m_ptr = 0;
    int m_rem = 0;

    iob_eth_rx_word_reader dut (
        .clk_i         (clk),
        .cke_i         (cke),
        .rst_i         (rst),
        .req_ren_i     (req_ren),
        .req_ready_o   (req_ready),
        .req_rdata_o   (req_rdata),
        .req_rvalid_o  (req_rvalid),
        .frame_rdy_i   (frame_rdy),
        .frame_len_i   (frame_len),
        .frame_ack_o   (frame_ack),
        .flush_i       (flush),
        .rx_remaining_o(rx_remaining),
        .buf_ren_o     (buf_ren),
        .buf_addr_o    (buf_addr),
        .buf_rdata_i   (buf_rdata)
    );

    always #5 clk = ~clk;

    // RX buffer RAM shares the clock enable
    always @(posedge clk) begin
        if (cke && buf_ren) buf_rdata <= mem[buf_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_ready", req_ready, 1);
        chk("rst_rvalid", req_rvalid, 0);
        chk("rst_rdata", req_rdata, 0);
        chk("rst_ack", frame_ack, 0);
        chk("rst_ren", buf_ren, 0);
        chk("rst_addr", buf_addr, 0);
        chk("rst_remaining", rx_remaining, 0);
    endtask

    task automatic load_frame(input int len);
        int exp_rem;
        exp_rem = (len > 2048) ? 2048 : len;
        chk("load_ready", req_ready, 1);
        frame_rdy = 1'b1;
        frame_len = 12'(len);
        step();
        frame_rdy = 1'b0;
        chk("load_ack", frame_ack, (exp_rem == 0));
        chk("load_remaining", rx_remaining, exp_rem);
        chk("load_ready_after", req_ready, 1);
        m_rem = exp_rem;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_ack", frame_ack, (m_rem > 0));
        chk("flush_remaining", rx_remaining, 0);
        m_ptr = (m_ptr + m_rem) % 2048;
        m_rem = 0;
    endtask

    // cke_at: cycle after acceptance where a 3-cycle clock-enable gap starts
    task automatic do_read(input int cke_at, input int flush_at,
                           input bit flush_req);
        int k;
        int exp_lat;
        int n;
        logic [31:0] exp_word;
        int addrs[$];
        k = (m_rem > 4) ? 4 : m_rem;
        exp_word = '0;
        for (int i = 0; i < k; i++)
            exp_word[8*i +: 8] = mem[(m_ptr + i) % 2048];
        exp_lat = (k == 0) ? 1 : k + 2;
        if (k > 0 && cke_at > 0) exp_lat += 3;
        chk("read_ready", req_ready, 1);
        req_ren = 1'b1;
        flush = flush_req;
        step();
        req_ren = 1'b0;
        flush = 1'b0;
        n = 1;
        while (n < 64) begin
            cke = !(cke_at > 0 && n >= cke_at && n < cke_at + 3);
            flush = (flush_at == n);
            if (req_rvalid) break;
            if (buf_ren && cke) addrs.push_back(int'(buf_addr));
            step();
            n++;
        end
        cke = 1'b1;
        flush = 1'b0;
        chk("read_rvalid_seen", req_rvalid, 1);
        chk("read_latency", n, exp_lat);
        chk("read_rdata", req_rdata, exp_word);
        chk("read_ack", frame_ack, (k > 0 && m_rem == k));
        chk("read_nbytes", addrs.size(), k);
        for (int i = 0; i < k; i++)
            if (i < addrs.size())
                chk("read_addr", addrs[i], (m_ptr + i) % 2048);
        m_ptr = (m_ptr + k) % 2048;
        m_rem = m_rem - k;
        chk("read_remaining", rx_remaining, m_rem);
        step();
        chk("read_rvalid_pulse", req_rvalid, 0);
        chk("read_ack_pulse", frame_ack, 0);
        chk("read_ready_back", req_ready, 1);
        chk("read_rdata_hold", req_rdata, exp_word);
    endtask

    task automatic do_reset_mid();
        req_ren = 1'b1;
        step();
        req_ren = 1'b0;
        chk("rstmid_ren", buf_ren, 1);
        step();
        rst = 1'b1;
        chk("rstmid_rvalid", req_rvalid, 0);
        step();
        rst = 1'b0;
        check_reset_outputs();
        m_ptr = 0;
        m_rem = 0;
    endtask

    initial begin
        cke = 1'b1;
        rst = 1'b1;
        req_ren = 1'b0;
        frame_rdy = 1'b0;
        frame_len = '0;
        flush = 1'b0;
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) mem[i] = 8'(8'h11 * (i + 1));
        repeat (3) step();
        check_reset_outputs();
        rst = 1'b0;
        step();

        do_read(0, 0, 0);
        load_frame(6);
        do_read(0, 0, 0);
        do_read(0, 0, 0);
        load_frame(0);
        do_read(0, 0, 0);
        do_flush();
        load_frame(10);
        do_read(0, 2, 0);
        do_flush();
        load_frame(2030);
        do_flush();
        load_frame(4);
        do_read(0, 0, 0);
        load_frame(3000);
        do_read(0, 0, 1);
        do_flush();
        load_frame(8);
        do_read(2, 0, 0);
        do_reset_mid();

        for (int it = 0; it < 80; it++) begin
            mem[$urandom_range(0, 2047)] = 8'($urandom);
            if (m_rem == 0) begin
                if ($urandom_range(0, 3) == 0)
                    do_read(0, 0, 1'($urandom));
                else if ($urandom_range(0, 7) == 0)
                    load_frame(0);
                else
                    load_frame($urandom_range(1, 20));
            end else begin
                case ($urandom_range(0, 9))
                    0: do_flush();
                    1: do_reset_mid();
                    default: do_read(($urandom_range(0, 2) == 0) ? 2 : 0,
                                     ($urandom_range(0, 1) == 0) ? 2 : 0,
                                     1'($urandom));
                endcase
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
